// File: rtl/membus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Membus : request/response memory bus between requesters and a memory slave
// Revision: 1.0
// ============================================================================
interface Membus #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] addr;
  logic            wen;
  logic [63:0]     wdata;
  logic [7:0]      wmask;
  logic            rvalid;
  logic [63:0]     rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
// membus_arbiter : fetch/data arbiter onto one memory bus, one outstanding txn
// Revision: 1.0
// ============================================================================
module membus_arbiter #(
  parameter int unsigned STREAK_MAX = 3
) (
  input  logic  clk,
  input  logic  rst,
  Membus.slave  i_membus,
  Membus.slave  d_membus,
  Membus.master membus
);

  localparam logic [1:0] STREAK_CAP = 2'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] streak_q, streak_d;

  logic issue_ok;
  logic gnt_d;
  logic gnt_i;
  logic handshake;

  // A returning response frees the bus in the same cycle, allowing back-to-back issue.
  assign issue_ok  = (state_q == IDLE) || membus.rvalid;
  assign gnt_d     = d_membus.valid && !(i_membus.valid && (streak_q == STREAK_CAP));
  assign gnt_i     = !gnt_d && i_membus.valid;
  assign handshake = membus.valid && membus.ready;

  assign membus.valid = issue_ok && (gnt_d || gnt_i);
  assign membus.addr  = gnt_i ? i_membus.addr  : d_membus.addr;
  assign membus.wen   = gnt_i ? i_membus.wen   : d_membus.wen;
  assign membus.wdata = gnt_i ? i_membus.wdata : d_membus.wdata;
  assign membus.wmask = gnt_i ? i_membus.wmask : d_membus.wmask;

  assign i_membus.ready = gnt_i && issue_ok && membus.ready;
  assign d_membus.ready = gnt_d && issue_ok && membus.ready;

  // Responses route by the current owner, even when a new request issues alongside.
  assign i_membus.rvalid = membus.rvalid && (state_q == WAIT_I);
  assign d_membus.rvalid = membus.rvalid && (state_q == WAIT_D);
  assign i_membus.rdata  = membus.rdata;
  assign d_membus.rdata  = membus.rdata;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (handshake) begin
      if (gnt_d) begin
        state_d = WAIT_D;
        if (i_membus.valid) begin
          streak_d = (streak_q == STREAK_CAP) ? streak_q : streak_q + 2'd1;
        end else begin
          streak_d = 2'd0;
        end
      end else begin
        state_d  = WAIT_I;
        streak_d = 2'd0;
      end
    end else if (membus.rvalid && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_membus_arbiter : directed self-checking bench with a latency-programmable slave
// Revision: 1.0
// ============================================================================
module tb_membus_arbiter;

  localparam logic [63:0] ST_IDLE   = 64'd0;
  localparam logic [63:0] ST_WAIT_I = 64'd1;
  localparam logic [63:0] ST_WAIT_D = 64'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  Membus #(.XLEN(32)) im ();
  Membus #(.XLEN(32)) dm ();
  Membus #(.XLEN(32)) mb ();

  membus_arbiter #(.STREAK_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_membus (im),
    .d_membus (dm),
    .membus   (mb)
  );

  int ncomp = 0;
  int nmis  = 0;

  // Slave model: response arrives 'lat' cycles after each handshake
  int          lat       = 1;
  int          cnt       = 0;
  logic        hs_prev   = 1'b0;
  logic        slv_ready = 1'b0;
  logic        slv_rv    = 1'b0;
  logic        force_rv  = 1'b0;
  logic [31:0] cap_addr  = 32'h0;

  assign mb.ready  = slv_ready;
  assign mb.rvalid = slv_rv || force_rv;
  assign mb.rdata  = {32'h0, cap_addr} ^ 64'h0000_0000_8000_0013;

  always @(posedge clk) begin
    hs_prev <= mb.valid && mb.ready;
    if (mb.valid && mb.ready) cap_addr <= mb.addr;
  end

  always @(negedge clk) begin
    if (hs_prev) cnt = lat;
    else if (cnt > 0) cnt = cnt - 1;
    slv_rv = (cnt == 1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_gnt;
  logic [1:0] prev_gnt;
  logic [4:0] b2b_ready;
  logic [4:0] b2b_rvalid;

  initial begin
    im.valid = 1'b0; im.addr = 32'h0; im.wen = 1'b0; im.wdata = 64'h0; im.wmask = 8'h0;
    dm.valid = 1'b0; dm.addr = 32'h0; dm.wen = 1'b0; dm.wdata = 64'h0; dm.wmask = 8'h0;
    slv_ready = 1'b1;
    lat = 1;
    prev_gnt = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_state",    64'(dut.state_q), ST_IDLE);
    check("rst_streak",   64'(dut.streak_q), 64'd0);
    check("rst_i_ready",  64'(im.ready), 64'd0);
    check("rst_d_ready",  64'(dm.ready), 64'd0);
    check("rst_i_rvalid", 64'(im.rvalid), 64'd0);
    check("rst_d_rvalid", 64'(dm.rvalid), 64'd0);
    check("rst_mb_valid", 64'(mb.valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, latency 1
    @(negedge clk);
    im.valid = 1'b1; im.addr = 32'h8000_0000;
    #1;
    check("fetch_i_ready",  64'(im.ready), 64'd1);
    check("fetch_d_ready",  64'(dm.ready), 64'd0);
    check("fetch_mb_valid", 64'(mb.valid), 64'd1);
    check("fetch_mb_addr",  64'(mb.addr), 64'h8000_0000);
    @(negedge clk);
    im.valid = 1'b0;
    #1;
    check("fetch_state",    64'(dut.state_q), ST_WAIT_I);
    check("fetch_i_rvalid", 64'(im.rvalid), 64'd1);
    check("fetch_rdata",    im.rdata, 64'h0000_0000_0000_0013);
    check("fetch_d_rvalid", 64'(dm.rvalid), 64'd0);
    @(negedge clk);
    #1;
    check("fetch_idle",     64'(dut.state_q), ST_IDLE);
    check("fetch_i_rv_off", 64'(im.rvalid), 64'd0);

    // Contention: expect D,D,D,I repeating; responses follow the previous grant
    dm.addr = 32'h0000_2000; im.addr = 32'h8000_0004;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      im.valid = 1'b1; dm.valid = 1'b1;
      #1;
      exp_gnt = ((k % 4) == 3) ? 2'b10 : 2'b01;
      check($sformatf("cont_grant%0d", k), 64'({im.ready, dm.ready}), 64'(exp_gnt));
      if (k > 0) check($sformatf("cont_rvalid%0d", k), 64'({im.rvalid, dm.rvalid}), 64'(prev_gnt));
      prev_gnt = exp_gnt;
    end
    @(negedge clk);
    im.valid = 1'b0; dm.valid = 1'b0;
    #1;
    check("cont_last_rvalid", 64'({im.rvalid, dm.rvalid}), 64'b10);
    check("cont_mb_valid",    64'(mb.valid), 64'd0);
    @(negedge clk);
    #1;
    check("cont_idle", 64'(dut.state_q), ST_IDLE);

    // Back-to-back data with latency 2: no IDLE bubble between transactions
    lat = 2;
    b2b_ready  = 5'b10101;
    b2b_rvalid = 5'b10100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dm.valid = 1'b1;
      #1;
      check($sformatf("b2b_d_ready%0d", k),  64'(dm.ready),  64'(b2b_ready[k]));
      check($sformatf("b2b_d_rvalid%0d", k), 64'(dm.rvalid), 64'(b2b_rvalid[k]));
      if (k > 0) check($sformatf("b2b_state%0d", k), 64'(dut.state_q), ST_WAIT_D);
    end
    check("b2b_streak", 64'(dut.streak_q), 64'd0);
    @(negedge clk);
    dm.valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("b2b_idle", 64'(dut.state_q), ST_IDLE);

    // Backpressure: slave not ready for 5 cycles, then accepts a masked write
    lat = 1;
    slv_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dm.valid = 1'b1; dm.wen = 1'b1; dm.addr = 32'h0000_1000;
      dm.wdata = 64'h0000_0000_DEAD_BEEF; dm.wmask = 8'h0F;
      #1;
      check($sformatf("bp_d_ready%0d", k), 64'(dm.ready), 64'd0);
      check($sformatf("bp_state%0d", k),   64'(dut.state_q), ST_IDLE);
    end
    @(negedge clk);
    slv_ready = 1'b1;
    #1;
    check("bp_d_ready_go", 64'(dm.ready), 64'd1);
    check("bp_wdata",      mb.wdata, 64'h0000_0000_DEAD_BEEF);
    check("bp_wmask",      64'(mb.wmask), 64'h0F);
    check("bp_wen",        64'(mb.wen), 64'd1);
    @(negedge clk);
    dm.valid = 1'b0; dm.wen = 1'b0; dm.wdata = 64'h0; dm.wmask = 8'h0;
    #1;
    check("bp_state_wait", 64'(dut.state_q), ST_WAIT_D);
    check("bp_d_rvalid",   64'(dm.rvalid), 64'd1);
    @(negedge clk);
    #1;
    check("bp_idle", 64'(dut.state_q), ST_IDLE);

    // Stray response while idle is dropped
    @(negedge clk);
    force_rv = 1'b1;
    #1;
    check("stray_d_rvalid", 64'(dm.rvalid), 64'd0);
    check("stray_i_rvalid", 64'(im.rvalid), 64'd0);
    @(negedge clk);
    force_rv = 1'b0;
    #1;
    check("stray_state", 64'(dut.state_q), ST_IDLE);

    // Reset while a data transaction is outstanding; late response discarded
    lat = 2;
    @(negedge clk);
    dm.valid = 1'b1; im.valid = 1'b1; dm.addr = 32'h0000_3000;
    #1;
    check("rmo_d_ready", 64'(dm.ready), 64'd1);
    @(negedge clk);
    dm.valid = 1'b0; im.valid = 1'b0;
    #1;
    check("rmo_state_pre",  64'(dut.state_q), ST_WAIT_D);
    check("rmo_streak_pre", 64'(dut.streak_q), 64'd1);
    rst = 1'b0;
    #1;
    check("rmo_state_async",  64'(dut.state_q), ST_IDLE);
    check("rmo_streak_async", 64'(dut.streak_q), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmo_late_d_rvalid", 64'(dm.rvalid), 64'd0);
    @(negedge clk);
    #1;
    check("rmo_state_post", 64'(dut.state_q), ST_IDLE);

    // Fetch handshake coinciding with the data response
    lat = 1;
    @(negedge clk);
    dm.valid = 1'b1; dm.addr = 32'h0000_4000;
    #1;
    check("ovl_d_ready", 64'(dm.ready), 64'd1);
    @(negedge clk);
    dm.valid = 1'b0; im.valid = 1'b1; im.addr = 32'h8000_0000;
    #1;
    check("ovl_d_rvalid",   64'(dm.rvalid), 64'd1);
    check("ovl_i_ready",    64'(im.ready), 64'd1);
    check("ovl_i_rvalid_0", 64'(im.rvalid), 64'd0);
    @(negedge clk);
    im.valid = 1'b0;
    #1;
    check("ovl_i_rvalid", 64'(im.rvalid), 64'd1);
    check("ovl_d_rv_off", 64'(dm.rvalid), 64'd0);
    check("ovl_rdata",    im.rdata, 64'h0000_0000_0000_0013);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 The module SHALL expose ports in this order: clk input 1 clock; rst input 1 asynchronous active-low reset.
REQ-002 i_membus SHALL be a Membus.slave port carrying instruction-fetch requests: valid, ready, addr[XLEN-1:0], wen, wdata[63:0], wmask[7:0], rvalid, rdata[63:0].
REQ-003 d_membus SHALL be a Membus.slave port carrying load/store requests, with the same fields as i_membus.
REQ-004 membus SHALL be a Membus.master port driving the shared memory/MMIO slave, with the same fields.
REQ-005 The parameter STREAK_MAX SHALL default to 3 and SHALL set the maximum number of consecutive data grants while a fetch waits.

Function
REQ-006 The arbiter SHALL use a state register with values IDLE, WAIT_I and WAIT_D, and SHALL allow at most one outstanding transaction.
REQ-007 issue_ok SHALL be (state==IDLE) || membus.rvalid, so a new request can issue in the same cycle the previous response returns.
REQ-008 The grant SHALL go to data when d.valid && !(i.valid && streak==STREAK_MAX); otherwise to fetch when i.valid; otherwise to neither.
REQ-009 The request path SHALL be combinational: membus.valid = issue_ok && the granted requester's valid; addr, wen, wdata and wmask SHALL come from the granted requester, or from d_membus when there is no grant.
REQ-010 Ready SHALL be: granted requester ready = issue_ok && membus.ready; non-granted requester ready = 0.
REQ-011 A handshake is membus.valid && membus.ready; on a handshake, state SHALL become WAIT_D or WAIT_I at the next edge, matching the grant.
REQ-012 When membus.rvalid is high with no handshake in the same cycle, state SHALL become IDLE.
REQ-013 d.rvalid SHALL equal membus.rvalid && state==WAIT_D, and i.rvalid SHALL equal membus.rvalid && state==WAIT_I.
REQ-014 rdata SHALL pass combinationally from membus.rdata to both requesters.
REQ-015 When membus.rvalid rises in the same cycle as a new handshake, the response SHALL route to the old owner (current state) and state SHALL move to the new owner.
REQ-016 membus.rvalid while state==IDLE SHALL be ignored: it is not forwarded and the state is unchanged.
REQ-017 The slave's response SHALL arrive no earlier than one cycle after the handshake; the arbiter does not support zero-latency responses.
REQ-018 streak[1:0] SHALL update only on a handshake cycle, as follows.
- Data grant with i.valid high: increment, saturating at STREAK_MAX.
- Data grant with i.valid low: clear to 0.
- Fetch grant: clear to 0.
REQ-019 Requester signals SHALL be held stable while valid && !ready; the arbiter need not latch them.
REQ-020 A grant SHALL be re-evaluated every cycle until its handshake; the grant is not sticky while membus.ready is low.

Reset
REQ-021 While rst is low, state SHALL be IDLE and streak SHALL be 0, taking effect immediately and asynchronously.
REQ-022 After reset, i.ready, d.ready, i.rvalid and d.rvalid SHALL be 0 until a request arrives, and membus.valid SHALL be 0.
REQ-023 Reset asserted while a transaction is outstanding SHALL drop it; a late response after reset SHALL be discarded per REQ-016.

Verification
REQ-024 Single fetch: i.valid with addr=0x8000_0000, slave ready=1 and latency 1 -> i.ready=1 in cycle 0, state WAIT_I, i.rvalid=1 with rdata=0x0000_0013 in cycle 1, d.rvalid=0 throughout.
REQ-025 Contention: i.valid and d.valid both high continuously, each slave latency 1 -> grants D,D,D,I,D,D,D,I; fetch never waits more than 3 data grants.
REQ-026 Back-to-back: d.valid held high, slave latency 2 -> a new data handshake occurs in every cycle where membus.rvalid=1, with no IDLE bubble; each rvalid goes to d.
REQ-027 Backpressure: d.valid high with membus.ready=0 for 5 cycles -> d.ready=0 and state stays IDLE; in the ready cycle the handshake occurs; wdata=0xDEAD_BEEF and wmask=0x0F reach membus unchanged.
REQ-028 Reset mid-op: rst pulsed low while in WAIT_D, slave then returns rvalid -> state IDLE, d.rvalid=0, streak=0.
REQ-029 Ownership on overlap: data outstanding while a fetch handshake coincides with the data rvalid -> d.rvalid=1 in that cycle and i.rvalid=1 on the following response.
